rv_mem_xlate: RTL and testbench

RV_MEM_XLATE -- requirements
Module: rv_mem_xlate

---
 rtl/rv_mem_xlate.sv | 161 ++++++++++++++++
 tb/tb_rv_mem_xlate.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_xlate.sv
// rv_mem_xlate: single-outstanding core-to-memory bridge with address translation.
// Core byte addresses are rebased by one of two offsets, split at ADDRESS_GATE,
// and truncated to a MEM_LEN-bit memory address.
// Optional feature macro: RV_MEM_RANGE_CHECK_EN. When defined, a translation that
// borrows or overflows MEM_LEN bits is answered with an error response and never
// reaches memory. When undefined, the result is silently truncated and err_o stays 0.
module rv_mem_xlate #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned MEM_LEN        = 20,
    parameter logic [XLEN-1:0] ADDRESS_GATE   = 32'h000F_FFFF,
    parameter logic [XLEN-1:0] ADDRESS_DEC_LT = 32'h0001_0094,
    parameter logic [XLEN-1:0] ADDRESS_DEC_GE = 32'h7FEF_FDB0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [3:0]         be_i,
    input  logic [XLEN-1:0]    addr_i,
    input  logic [XLEN-1:0]    wdata_i,
    output logic               gnt_o,
    output logic               rvalid_o,
    output logic [XLEN-1:0]    rdata_o,
    output logic               err_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [3:0]         mem_be_o,
    output logic [MEM_LEN-1:0] mem_addr_o,
    output logic [XLEN-1:0]    mem_wdata_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [XLEN-1:0]    mem_rdata_i
);

    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        ERR_RSP  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_n;
    logic                accept;
    logic [XLEN-1:0]     dec_sel;
    logic [MEM_LEN-1:0]  xaddr;
    logic                range_err;

    logic                mem_req_n;
    logic                mem_we_n;
    logic [BE_W-1:0]     mem_be_n;
    logic [MEM_LEN-1:0]  mem_addr_n;
    logic [XLEN-1:0]     mem_wdata_n;
    logic                rvalid_n;
    logic                err_n;
    logic [XLEN-1:0]     rdata_n;

    // Pick the rebasing offset for the region the address falls in.
    assign dec_sel = (addr_i < ADDRESS_GATE) ? ADDRESS_DEC_LT : ADDRESS_DEC_GE;

`ifdef RV_MEM_RANGE_CHECK_EN
    logic [XLEN:0] diff;

    // Extra top bit captures the borrow of the modulo subtraction.
    assign diff      = {1'b0, addr_i} - {1'b0, dec_sel};
    assign xaddr     = diff[MEM_LEN-1:0];
    assign range_err = diff[XLEN] | (|diff[XLEN-1:MEM_LEN]);
`else
    // Unchecked translation: keep only the memory-address bits.
    assign xaddr     = MEM_LEN'(addr_i - dec_sel);
    assign range_err = 1'b0;
`endif

    // Grant is combinational so the core sees acceptance in the request cycle.
    assign gnt_o  = req_i && (state == IDLE) && !rst_i;
    assign accept = gnt_o;

    // Next-state and next-output decode.
    always_comb begin
        state_n     = state;
        mem_req_n   = mem_req_o;
        mem_we_n    = mem_we_o;
        mem_be_n    = mem_be_o;
        mem_addr_n  = mem_addr_o;
        mem_wdata_n = mem_wdata_o;
        rvalid_n    = 1'b0;
        err_n       = 1'b0;
        rdata_n     = rdata_o;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    mem_we_n    = we_i;
                    mem_be_n    = be_i;
                    mem_addr_n  = xaddr;
                    mem_wdata_n = wdata_i;
                    if (range_err) begin
                        state_n = ERR_RSP;
                    end else begin
                        state_n   = ISSUE;
                        mem_req_n = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (mem_gnt_i) begin
                    mem_req_n = 1'b0;
                    state_n   = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem_rvalid_i) begin
                    rdata_n  = mem_rdata_i;
                    rvalid_n = 1'b1;
                    state_n  = IDLE;
                end
            end
            ERR_RSP: begin
                rvalid_n = 1'b1;
                err_n    = 1'b1;
                rdata_n  = '0;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Registered outputs; reset drops any in-flight transaction silently.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rvalid_o    <= 1'b0;
            err_o       <= 1'b0;
            rdata_o     <= '0;
        end else begin
            mem_req_o   <= mem_req_n;
            mem_we_o    <= mem_we_n;
            mem_be_o    <= mem_be_n;
            mem_addr_o  <= mem_addr_n;
            mem_wdata_o <= mem_wdata_n;
            rvalid_o    <= rvalid_n;
            err_o       <= err_n;
            rdata_o     <= rdata_n;
        end
    end

endmodule

// File: tb/tb_rv_mem_xlate.sv
// Bench for rv_mem_xlate: directed transactions, a transaction-level model of the
// expected response/memory-request windows, and a per-cycle compare process.
module tb_rv_mem_xlate;

    localparam logic [31:0] GATE   = 32'h000F_FFFF;
    localparam longint      DEC_LT = 64'h0000_0000_0001_0094;
    localparam longint      DEC_GE = 64'h0000_0000_7FEF_FDB0;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [19:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    rv_mem_xlate dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .we_i         (we_i),
        .be_i         (be_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .gnt_o        (gnt_o),
        .rvalid_o     (rvalid_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } pulse_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic        rst_seen;
    pulse_t      pulses[$];
    logic [31:0] model_rdata = '0;
    int          mreq_lo = 1, mreq_hi = 0;
    int          busy_lo = 1, busy_hi = 0;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [19:0] exp_addr;
    logic [31:0] exp_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // Translation rule from the address map: {error, memory address}.
    function automatic logic [20:0] xlate(input logic [31:0] a);
        longint base;
        longint d;
        logic   e;
        base = (a < GATE) ? DEC_LT : DEC_GE;
        d    = longint'({32'd0, a}) - base;
        e    = 1'b0;
`ifdef RV_MEM_RANGE_CHECK_EN
        e = (d < 0) || (d >= 64'sd1048576);
`endif
        return {e, d[19:0]};
    endfunction

    // Per-cycle compare against the model windows.
    initial begin
        forever begin
            @(posedge clk_i);
            cyc++;
            rst_seen = rst_i;
            @(negedge clk_i);
            if (rst_seen) begin
                pulses.delete();
                model_rdata = '0;
                chk("rst_rvalid", 32'(rvalid_o), 32'd0);
                chk("rst_err", 32'(err_o), 32'd0);
                chk("rst_rdata", rdata_o, 32'd0);
                chk("rst_mem_req", 32'(mem_req_o), 32'd0);
                chk("rst_mem_we", 32'(mem_we_o), 32'd0);
                chk("rst_mem_be", 32'(mem_be_o), 32'd0);
                chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
                chk("rst_mem_wdata", mem_wdata_o, 32'd0);
            end else begin
                logic exp_rv;
                logic exp_err;
                logic exp_mreq;
                exp_rv  = (pulses.size() > 0) && (pulses[0].cyc == cyc);
                exp_err = 1'b0;
                if (exp_rv) begin
                    model_rdata = pulses[0].rdata;
                    exp_err     = pulses[0].err;
                    void'(pulses.pop_front());
                end
                chk("rvalid", 32'(rvalid_o), 32'(exp_rv));
                chk("err", 32'(err_o), 32'(exp_err));
                chk("rdata", rdata_o, model_rdata);
                exp_mreq = (cyc >= mreq_lo) && (cyc <= mreq_hi);
                chk("mem_req", 32'(mem_req_o), 32'(exp_mreq));
                if (exp_mreq) begin
                    chk("mem_we", 32'(mem_we_o), 32'(exp_we));
                    chk("mem_be", 32'(mem_be_o), 32'(exp_be));
                    chk("mem_addr", 32'(mem_addr_o), 32'(exp_addr));
                    chk("mem_wdata", mem_wdata_o, exp_wdata);
                end
            end
            chk("gnt", 32'(gnt_o),
                32'(req_i && !rst_i && !((cyc >= busy_lo) && (cyc <= busy_hi))));
        end
    end

    // One core transaction; called just after a clock edge with the bridge idle.
    task automatic run_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata, input int stall, input logic [31:0] rd,
                           input logic lit_en, input logic [19:0] lit_addr);
        logic [20:0] x;
        int          a;
        int          p;
        x         = xlate(addr);
        a         = cyc + 1;
        req_i     = 1'b1;
        we_i      = we;
        be_i      = be;
        addr_i    = addr;
        wdata_i   = wdata;
        exp_we    = we;
        exp_be    = be;
        exp_addr  = x[19:0];
        exp_wdata = wdata;
        busy_lo   = a;
        if (x[20]) begin
            mreq_lo = 1;
            mreq_hi = 0;
            busy_hi = a;
            pulses.push_back('{cyc: a + 1, rdata: 32'd0, err: 1'b1});
        end else begin
            p       = a + stall + 2;
            mreq_lo = a;
            mreq_hi = a + stall;
            busy_hi = p - 1;
            pulses.push_back('{cyc: p, rdata: rd, err: 1'b0});
        end
        @(posedge clk_i); #1;
        if (stall == 0) req_i = 1'b0;
        if (lit_en) chk("lit_mem_addr", 32'(mem_addr_o), 32'(lit_addr));
        if (x[20]) begin
            @(posedge clk_i); #1;
            chk("lit_err_rvalid", 32'(rvalid_o), 32'd1);
            chk("lit_err_err", 32'(err_o), 32'd1);
            chk("lit_err_rdata", rdata_o, 32'd0);
            return;
        end
        mem_gnt_i    = (stall == 0);
        mem_rvalid_i = (stall > 0);
        repeat (stall) begin
            @(posedge clk_i); #1;
            mem_rvalid_i = 1'b0;
            if (cyc == a + stall) begin
                mem_gnt_i = 1'b1;
                req_i     = 1'b0;
            end
        end
        @(posedge clk_i); #1;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = rd;
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
        if (lit_en) begin
            chk("lit_rvalid", 32'(rvalid_o), 32'd1);
            chk("lit_rdata", rdata_o, rd);
        end
    endtask

    // Reset pulsed while waiting for the memory response; the late response is dropped.
    task automatic reset_mid();
        int a;
        a         = cyc + 1;
        req_i     = 1'b1;
        we_i      = 1'b0;
        be_i      = 4'hF;
        addr_i    = 32'h0001_0100;
        wdata_i   = 32'd0;
        exp_we    = 1'b0;
        exp_be    = 4'hF;
        exp_addr  = 20'h0006C;
        exp_wdata = 32'd0;
        busy_lo   = a;
        busy_hi   = a + 1;
        mreq_lo   = a;
        mreq_hi   = a;
        @(posedge clk_i); #1;
        req_i     = 1'b0;
        mem_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        mem_gnt_i = 1'b0;
        rst_i     = 1'b1;
        @(posedge clk_i); #1;
        rst_i     = 1'b0;
        chk("lit_rst_rdata", rdata_o, 32'd0);
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h5555_AAAA;
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0;
        @(posedge clk_i); #1;
        chk("lit_late_rvalid", 32'(rvalid_o), 32'd0);
    endtask

    initial begin
        rst_i        = 1'b1;
        req_i        = 1'b0;
        we_i         = 1'b0;
        be_i         = 4'h0;
        addr_i       = 32'd0;
        wdata_i      = 32'd0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'd0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i); #1;

        run_txn(1'b0, 4'hF, 32'h0001_0100, 32'd0, 0, 32'hDEAD_BEEF, 1'b1, 20'h0006C);
        run_txn(1'b1, 4'b0011, 32'h7FF0_0000, 32'h1234_5678, 0, 32'hCAFE_0001, 1'b1, 20'h00250);
        run_txn(1'b0, 4'hF, 32'h000F_FFFE, 32'd0, 1, 32'h1111_1111, 1'b1, 20'hEFF6A);
`ifdef RV_MEM_RANGE_CHECK_EN
        run_txn(1'b0, 4'hF, 32'h000F_FFFF, 32'd0, 0, 32'h2222_2222, 1'b0, 20'h0);
`else
        run_txn(1'b0, 4'hF, 32'h000F_FFFF, 32'd0, 0, 32'h2222_2222, 1'b1, 20'h0024F);
`endif
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h7777_7777;
        @(posedge clk_i); #1;
        mem_rvalid_i = 1'b0;
`ifdef RV_MEM_RANGE_CHECK_EN
        run_txn(1'b0, 4'hF, 32'h0000_1000, 32'd0, 0, 32'h3333_3333, 1'b0, 20'h0);
`else
        run_txn(1'b0, 4'hF, 32'h0000_1000, 32'd0, 0, 32'h3333_3333, 1'b1, 20'hF0F6C);
`endif
        run_txn(1'b1, 4'b1100, 32'h0002_0000, 32'hA5A5_5A5A, 5, 32'h0BAD_F00D, 1'b1, 20'h0FF6C);
        reset_mid();
`ifdef RV_MEM_RANGE_CHECK_EN
        run_txn(1'b0, 4'hF, 32'h8000_0000, 32'd0, 0, 32'h4444_4444, 1'b0, 20'h0);
`else
        run_txn(1'b0, 4'hF, 32'h8000_0000, 32'd0, 0, 32'h4444_4444, 1'b1, 20'h00250);
`endif
        run_txn(1'b0, 4'h1, 32'h0001_0094, 32'd0, 2, 32'h0F0F_0F0F, 1'b1, 20'h00000);
        run_txn(1'b1, 4'h8, 32'h0001_0098, 32'hFEED_FACE, 0, 32'h6666_6666, 1'b1, 20'h00004);
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
